// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the IF stage and imem.
//   imem_req   : request valid (fetch -> memory)
//   imem_addr  : request address, stable while imem_req && !imem_ready
//   imem_rdata : returned instruction, valid with imem_ready
//   imem_ready : response strobe for the current request
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// Pipeline IF stage: owns the PC, the imem request handshake and the IF/ID
// register. Publishes F_instr/pc to the hazard unit and obeys its stall.
// Redirects (branch_taken/jump) flush IF/ID and take priority over stall.
// Ports:
//   clock, reset          : clock and async active-high reset
//   stall                 : hold PC and IF/ID
//   branch_taken/_target  : branch redirect (wins over jump)
//   jump/jump_target      : jump redirect
//   imem                  : instruction-memory handshake (master side)
//   pc                    : current fetch PC
//   F_instr               : instruction currently in fetch (combinational)
//   IF_ID_instr/pc4/valid : IF/ID pipeline register
//   imem_timeout          : sticky, request unanswered WAIT_LIMIT cycles
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                jump,
    input  logic [31:0]         jump_target,
    fetch_stage_if.master       imem,
    output logic [31:0]         pc,
    output logic [31:0]         F_instr,
    output logic [31:0]         IF_ID_instr,
    output logic [31:0]         IF_ID_pc4,
    output logic                IF_ID_valid,
    output logic                imem_timeout
);
    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_buf, hold_nxt;
    logic [31:0] sq_addr, sq_addr_nxt;     // abandoned address kept on the bus in SQUASH
    logic [7:0]  wait_cnt, wait_nxt;
    logic        timeout_nxt;
    logic [31:0] pc_nxt, pc_plus4;
    logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
    logic        ifid_valid_nxt;
    logic        redirect;
    logic [31:0] target;
    logic        req;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign req      = (state == FETCH) || (state == SQUASH);

    assign imem.imem_req  = req;
    assign imem.imem_addr = (state == SQUASH) ? sq_addr : pc;

    always_comb begin
        F_instr = NOP_INSTR;
        if (state == FETCH && imem.imem_ready)
            F_instr = imem.imem_rdata;
        else if (state == HOLD)
            F_instr = hold_buf;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_nxt       = hold_buf;
        sq_addr_nxt    = sq_addr;
        ifid_instr_nxt = IF_ID_instr;
        ifid_pc4_nxt   = IF_ID_pc4;
        ifid_valid_nxt = IF_ID_valid;

        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem.imem_ready && !stall) begin
                    ifid_instr_nxt = imem.imem_rdata;
                    ifid_pc4_nxt   = pc_plus4;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc_plus4;
                end else if (imem.imem_ready) begin
                    // Keep the returned word so it is not re-fetched after the stall.
                    hold_nxt  = imem.imem_rdata;
                    state_nxt = HOLD;
                end else if (!stall) begin
                    ifid_instr_nxt = NOP_INSTR;
                    ifid_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    ifid_instr_nxt = hold_buf;
                    ifid_pc4_nxt   = pc_plus4;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc_plus4;
                    state_nxt      = FETCH;
                end
            end
            SQUASH: begin
                if (imem.imem_ready)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect overrides everything above; the sequential word is dropped.
        if (redirect) begin
            pc_nxt = target;
            if (state == SQUASH) begin
                state_nxt = SQUASH;
            end else begin
                hold_nxt       = NOP_INSTR;
                ifid_instr_nxt = NOP_INSTR;
                ifid_valid_nxt = 1'b0;
                if (state == FETCH && !imem.imem_ready) begin
                    // Outstanding request must complete before a new address is issued.
                    state_nxt   = SQUASH;
                    sq_addr_nxt = pc;
                end else begin
                    state_nxt = FETCH;
                end
            end
        end
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (imem.imem_ready)
            wait_nxt = '0;
        else if (req && wait_cnt != LIMIT)
            wait_nxt = wait_cnt + 8'd1;
        timeout_nxt = imem_timeout | (wait_nxt == LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            hold_buf     <= NOP_INSTR;
            sq_addr      <= RESET_PC;
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
            IF_ID_instr  <= NOP_INSTR;
            IF_ID_pc4    <= '0;
            IF_ID_valid  <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            hold_buf     <= hold_nxt;
            sq_addr      <= sq_addr_nxt;
            wait_cnt     <= wait_nxt;
            imem_timeout <= timeout_nxt;
            IF_ID_instr  <= ifid_instr_nxt;
            IF_ID_pc4    <= ifid_pc4_nxt;
            IF_ID_valid  <= ifid_valid_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc, F_instr, IF_ID_instr, IF_ID_pc4;
    logic        IF_ID_valid, imem_timeout;

    fetch_stage_if bus();

    // Memory model: every address returns addr | A000_0000.
    assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .WAIT_LIMIT(255)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem(bus.master),
        .pc(pc), .F_instr(F_instr), .IF_ID_instr(IF_ID_instr),
        .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid),
        .imem_timeout(imem_timeout)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;   // only checked when e_valid
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_fi;
    } vec_t;

    vec_t vt[22];

    initial begin
        // stall br bt jmp jt rdy | pc valid instr pc4 req addr F_instr
        vt[0]  = '{0,0,0,0,0,1, 32'h0,  0, 32'h0,         32'h0,  1, 32'h0,  32'hA000_0000};
        vt[1]  = '{0,0,0,0,0,1, 32'h4,  1, 32'hA000_0000, 32'h4,  1, 32'h4,  32'hA000_0004};
        vt[2]  = '{0,0,0,0,0,1, 32'h8,  1, 32'hA000_0004, 32'h8,  1, 32'h8,  32'hA000_0008};
        vt[3]  = '{1,0,0,0,0,1, 32'h8,  1, 32'hA000_0004, 32'h8,  0, 32'h8,  32'hA000_0008};
        vt[4]  = '{1,0,0,0,0,1, 32'h8,  1, 32'hA000_0004, 32'h8,  0, 32'h8,  32'hA000_0008};
        vt[5]  = '{1,0,0,0,0,1, 32'h8,  1, 32'hA000_0004, 32'h8,  0, 32'h8,  32'hA000_0008};
        vt[6]  = '{0,0,0,0,0,1, 32'hC,  1, 32'hA000_0008, 32'hC,  1, 32'hC,  32'hA000_000C};
        vt[7]  = '{0,0,0,0,0,1, 32'h10, 1, 32'hA000_000C, 32'h10, 1, 32'h10, 32'hA000_0010};
        vt[8]  = '{1,1,32'h40,0,0,1, 32'h40, 0, 32'h0, 32'h0, 1, 32'h40, 32'hA000_0040};
        vt[9]  = '{0,0,0,0,0,1, 32'h44, 1, 32'hA000_0040, 32'h44, 1, 32'h44, 32'hA000_0044};
        vt[10] = '{0,0,0,1,32'h20,1, 32'h20, 0, 32'h0, 32'h0, 1, 32'h20, 32'hA000_0020};
        vt[11] = '{0,0,0,0,0,0, 32'h20, 0, 32'h0, 32'h0, 1, 32'h20, 32'h0};
        vt[12] = '{0,1,32'h80,0,0,0, 32'h80, 0, 32'h0, 32'h0, 1, 32'h20, 32'h0};
        vt[13] = '{0,0,0,0,0,0, 32'h80, 0, 32'h0, 32'h0, 1, 32'h20, 32'h0};
        vt[14] = '{0,0,0,0,0,1, 32'h80, 0, 32'h0, 32'h0, 1, 32'h80, 32'hA000_0080};
        vt[15] = '{0,0,0,0,0,1, 32'h84, 1, 32'hA000_0080, 32'h84, 1, 32'h84, 32'hA000_0084};
        vt[16] = '{0,1,32'h100,1,32'h200,1, 32'h100, 0, 32'h0, 32'h0, 1, 32'h100, 32'hA000_0100};
        vt[17] = '{0,0,0,0,0,1, 32'h104, 1, 32'hA000_0100, 32'h104, 1, 32'h104, 32'hA000_0104};
        vt[18] = '{0,0,0,1,32'hFFFF_FFFC,1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vt[19] = '{0,0,0,0,0,1, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, 32'hA000_0000};
        vt[20] = '{1,0,0,0,0,0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, 32'h0};
        vt[21] = '{0,0,0,0,0,1, 32'h4, 1, 32'hA000_0000, 32'h4, 1, 32'h4, 32'hA000_0004};

        bus.imem_ready = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_timeout", {31'b0, imem_timeout}, 32'h0);

        step();
        step();
        reset = 1'b0;

        for (int unsigned i = 0; i < 22; i++) begin
            stall          = vt[i].stall;
            branch_taken   = vt[i].br;
            branch_target  = vt[i].bt;
            jump           = vt[i].jmp;
            jump_target    = vt[i].jt;
            bus.imem_ready = vt[i].rdy;
            step();
            chk($sformatf("v%0d_pc", i), pc, vt[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'b0, IF_ID_valid}, {31'b0, vt[i].e_valid});
            chk($sformatf("v%0d_instr", i), IF_ID_instr, vt[i].e_instr);
            if (vt[i].e_valid)
                chk($sformatf("v%0d_pc4", i), IF_ID_pc4, vt[i].e_pc4);
            chk($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vt[i].e_req});
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_finstr", i), F_instr, vt[i].e_fi);
            chk($sformatf("v%0d_timeout", i), {31'b0, imem_timeout}, 32'h0);
        end
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;

        // Timeout: 255 consecutive unanswered request cycles.
        bus.imem_ready = 1'b0;
        repeat (254) step();
        chk("to_254", {31'b0, imem_timeout}, 32'h0);
        step();
        chk("to_255", {31'b0, imem_timeout}, 32'h1);
        repeat (3) step();
        chk("to_sat", {31'b0, imem_timeout}, 32'h1);
        bus.imem_ready = 1'b1;
        repeat (3) step();
        chk("to_sticky", {31'b0, imem_timeout}, 32'h1);
        chk("to_pc_adv", pc, 32'h10);

        // Asynchronous reset mid-cycle with a request on the bus.
        bus.imem_ready = 1'b0;
        step();
        chk("pre_rst_req", {31'b0, bus.imem_req}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("arst_timeout", {31'b0, imem_timeout}, 32'h0);
        chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'b0, IF_ID_valid}, 32'h0);

        // Redirect during the IDLE cycle after reset release.
        step();
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        jump = 1'b1; jump_target = 32'h300;
        step();
        jump = 1'b0;
        chk("idle_jmp_pc", pc, 32'h300);
        chk("idle_jmp_req", {31'b0, bus.imem_req}, 32'h1);
        chk("idle_jmp_addr", bus.imem_addr, 32'h300);
        step();
        chk("idle_jmp_instr", IF_ID_instr, 32'hA000_0300);
        chk("idle_jmp_pc4", IF_ID_pc4, 32'h304);
        chk("idle_jmp_valid", {31'b0, IF_ID_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline IF stage sitting directly upstream of the branch hazard/forwarding unit.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Publishes the fetch-stage instruction (F_instr) and pc that the hazard unit inspects, and consumes that unit's stall.
- Applies branch/jump redirects with a flush, and never re-fetches an instruction already returned while stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding inserted into IF/ID and F_instr.
- WAIT_LIMIT, 255, consecutive unanswered request cycles before imem_timeout sets (8-bit counter).

Ports:
- clock  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; all state cleared immediately.
- stall  input  1  hold PC and IF/ID (from hazard unit).
- branch_taken  input  1  redirect to branch_target this cycle.
- branch_target  input  32  branch destination.
- jump  input  1  redirect to jump_target.
- jump_target  input  32  jump destination.
- imem_req  output  1  instruction memory request valid.
- imem_addr  output  32  request address; stable while imem_req=1 && !imem_ready.
- imem_rdata  input  32  returned instruction, valid when imem_ready=1.
- imem_ready  input  1  response strobe for the current request.
- pc  output  32  current fetch PC register.
- F_instr  output  32  instruction in fetch stage (combinational).
- IF_ID_instr  output  32  registered instruction to decode.
- IF_ID_pc4  output  32  registered PC+4 of that instruction.
- IF_ID_valid  output  1  IF/ID holds a real instruction.
- imem_timeout  output  1  sticky: request unanswered WAIT_LIMIT cycles.

Behaviour:
- Reset values (asynchronous):
  - pc=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_pc4=0, IF_ID_valid=0.
  - state=IDLE, hold buffer=NOP_INSTR, wait counter=0, imem_timeout=0.
  - imem_req=0, imem_addr=RESET_PC.
- States: IDLE, FETCH, HOLD, SQUASH.
- IDLE:
  - imem_req=0. Next cycle goes to FETCH unconditionally (one dead cycle after reset release).
  - A redirect in IDLE loads pc=target.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready && !stall: IF_ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH.
  - imem_ready && stall: capture imem_rdata into the hold buffer; IF_ID unchanged; pc unchanged; go to HOLD.
  - !imem_ready && !stall: IF_ID <= bubble (NOP_INSTR, valid=0); pc unchanged.
  - !imem_ready && stall: everything holds.
- HOLD:
  - imem_req=0.
  - !stall: IF_ID <= {hold buffer, pc+4, 1}; pc <= pc+4; go to FETCH.
  - stall: remain in HOLD.
- SQUASH:
  - imem_req=1 with imem_addr held at the abandoned address until imem_ready.
  - The returned data is discarded, then go to FETCH (pc already holds the target).
- Redirect (branch_taken || jump) has priority over stall in every state:
  - pc <= branch_taken ? branch_target : jump_target (branch_taken wins if both are asserted).
  - IF_ID <= bubble; hold buffer discarded.
  - From FETCH with !imem_ready: go to SQUASH.
  - Otherwise (including FETCH with imem_ready, where the data is dropped): go to FETCH.
  - Redirect in SQUASH: only pc updates; the state stays SQUASH.
- No delay slot: the sequential instruction fetched in the redirect cycle is never written to IF/ID.
- F_instr:
  - imem_rdata when state=FETCH && imem_ready.
  - Hold buffer when state=HOLD.
  - Otherwise NOP_INSTR (NOP decodes as a non-branch, so the hazard unit does not stall on bubbles).
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Target low bits are used unchanged.
- Wait counter:
  - Increments each cycle with imem_req && !imem_ready, saturating at WAIT_LIMIT.
  - Clears on imem_ready.
  - On reaching WAIT_LIMIT, imem_timeout sets and stays set until reset. Fetch behaviour is unaffected.
- Reset asserted mid-request: imem_req drops in the same cycle; any in-flight response is ignored.

Test Plan:
- Release reset, imem_ready tied 1, mem[addr]=addr|32'hA000_0000: IF_ID_valid first rises 2 cycles after release with IF_ID_instr=32'hA000_0000, IF_ID_pc4=4; pc then advances by 4 every cycle.
- stall=1 for 3 cycles coinciding with the return of the instruction at pc=8: state goes to HOLD, imem_req=0, F_instr stays at mem[8], IF_ID is frozen. After stall drops, IF_ID_instr=mem[8], IF_ID_pc4=12, and address 8 is not re-requested.
- branch_taken=1, branch_target=32'h40 at pc=0x10 with stall=1: next cycle pc=0x40, IF_ID_valid=0, IF_ID_instr=NOP. The next request address is 0x40.
- Redirect to 0x80 while the request for 0x20 is pending (imem_ready=0 for 2 cycles): imem_addr stays at 0x20 until ready, that data is discarded, and the next request is 0x80. No instruction from 0x20 reaches IF/ID.
- branch_taken and jump asserted together (targets 0x100, 0x200): pc=0x100.
- imem_ready held 0 for 255 cycles: imem_timeout rises exactly at the 255th waiting cycle and stays 1 after ready returns. Reset clears it asynchronously mid-cycle.
